// File: rtl/stream_demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared types and constants for the stream_demux block.
//   demux_mode_t : target selection mode (sideband select or round-robin)
//   DEMUX_*_DEF  : default word width / channel count
//   BEAT_CNT_W   : width of the delivered-word counter
//   rr_next()    : next round-robin pointer value, wrapping at n-1
// ----------------------------------------------------------------------------
package demux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } demux_mode_t;

  localparam int DEMUX_WIDTH_DEF = 4;
  localparam int DEMUX_N_DEF     = 4;
  localparam int BEAT_CNT_W      = 8;

  // Pointer wraps explicitly at n-1 so non power-of-two channel counts never
  // address a channel that does not exist.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned n);
    if (ptr >= (n - 32'd1)) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// ----------------------------------------------------------------------------
// stream_demux_if
// Bundles the input stream and the N output channels of stream_demux.
//   in_data/in_sel/in_mode/in_valid/in_ready : single input stream + sideband
//   out_data  : N*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   out_valid : per-channel slot full
//   out_ready : per-channel consumer ready
// Modports: slave = the demux itself, master = the producer/consumer side.
// ----------------------------------------------------------------------------
interface stream_demux_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int N     = DEMUX_N_DEF
);

  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0]   in_data;
  logic [SELW-1:0]    in_sel;
  logic               in_mode;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport slave (
    input  in_data, in_sel, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_sel, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/stream_demux_slot.sv
// ----------------------------------------------------------------------------
// demux_slot
// One-entry holding register for a single output channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : accept din this cycle (wins over drain: data replaced)
//   din        : word to capture
//   drain      : consumer ready; empties the slot when not reloaded
//   valid      : slot full (registered)
//   data       : held word (registered; keeps last value after draining)
// ----------------------------------------------------------------------------
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Slot occupancy: load has priority so a drain+load keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Slot payload: captured only on load, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= din;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
// Registered 1-to-N stream demultiplexer. Each accepted input word is steered
// to one channel's one-entry slot, chosen by in_sel (MODE_SEL) or by an
// internal round-robin pointer (MODE_RR). Backpressure is per target channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_demux_if.slave (input stream + N output channels)
//   rr_ptr     : current round-robin pointer
//   sel_err    : one-cycle pulse after a word addressed past N-1 was dropped
//   beat_cnt   : words delivered into slots, wraps modulo 256
// ----------------------------------------------------------------------------
module stream_demux
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH_DEF,
  parameter  int N     = DEMUX_N_DEF,
  localparam int SELW  = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_demux_if.slave         bus,
  output logic [SELW-1:0]       rr_ptr,
  output logic                  sel_err,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  demux_mode_t           mode_s;
  logic [SELW-1:0]       tgt_s;
  logic                  tgt_ok_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [N-1:0]          load_s;
  logic [N-1:0]          valid_s;
  logic [WIDTH-1:0]      data_s [N];
  logic [SELW-1:0]       rr_ptr_r;
  logic                  sel_err_r;
  logic [BEAT_CNT_W-1:0] beat_cnt_r;

  // Target channel for this cycle and whether that channel exists (a select
  // past N-1 is only reachable in MODE_SEL with non power-of-two N).
  always_comb begin
    mode_s = demux_mode_t'(bus.in_mode);
    if (mode_s == MODE_RR) begin
      tgt_s = rr_ptr_r;
    end else begin
      tgt_s = bus.in_sel;
    end
    tgt_ok_s = (32'(tgt_s) < N);
  end

  // Input ready: a nonexistent target always accepts (and drops); otherwise
  // the target slot must be empty or draining this cycle. No in_data path.
  always_comb begin
    in_ready_s = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (tgt_ok_s && (32'(tgt_s) == k)) begin
        in_ready_s = ~valid_s[k] | bus.out_ready[k];
      end else begin
        in_ready_s = in_ready_s;
      end
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // One-hot load strobe to the addressed slot for an accepted, valid target.
  always_comb begin
    load_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      load_s[k] = accept_s & tgt_ok_s & (32'(tgt_s) == k);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s[k]),
      .din   (bus.in_data),
      .drain (bus.out_ready[k]),
      .valid (valid_s[k]),
      .data  (data_s[k])
    );
  end

  // Pack the per-channel slot payloads onto the flat output bus.
  always_comb begin
    bus.out_data = {(N*WIDTH){1'b0}};
    for (int k = 0; k < N; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = data_s[k];
    end
  end

  assign bus.out_valid = valid_s;
  assign bus.in_ready  = in_ready_s;

  // Round-robin pointer: moves only on an accepted word in MODE_RR, so a
  // stalled channel stalls the input rather than being skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {SELW{1'b0}};
    end else if (accept_s && (mode_s == MODE_RR)) begin
      rr_ptr_r <= SELW'(rr_next(32'(rr_ptr_r), N));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Discard indication, registered so it pulses the cycle after the drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= accept_s & ~tgt_ok_s;
    end
  end

  // Delivered-word counter: counts slot loads only, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {BEAT_CNT_W{1'b0}};
    end else if (accept_s && tgt_ok_s) begin
      beat_cnt_r <= beat_cnt_r + BEAT_CNT_W'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign rr_ptr   = rr_ptr_r;
  assign sel_err  = sel_err_r;
  assign beat_cnt = beat_cnt_r;

endmodule

// File: tb/tb_stream_demux.sv
// ----------------------------------------------------------------------------
// tb_stream_demux
// Self-checking bench for stream_demux: directed scenarios on a 4-channel
// instance and a 3-channel instance (out-of-range select), plus randomized
// traffic compared against a slot-level behavioural model.
// ----------------------------------------------------------------------------
module tb_stream_demux;
  import demux_pkg::*;

  localparam int W  = 4;
  localparam int NA = 4;
  localparam int NB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(W), .N(NA)) ifa ();
  stream_demux_if #(.WIDTH(W), .N(NB)) ifb ();

  logic [1:0] rr_a, rr_b;
  logic       err_a, err_b;
  logic [7:0] beat_a, beat_b;

  stream_demux #(.WIDTH(W), .N(NA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .rr_ptr(rr_a), .sel_err(err_a), .beat_cnt(beat_a)
  );

  stream_demux #(.WIDTH(W), .N(NB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .rr_ptr(rr_b), .sel_err(err_b), .beat_cnt(beat_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the 4-channel instance
  bit         m_full [NA];
  logic [3:0] m_data [NA];
  int         m_ptr;
  int         m_beat;
  bit         m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.in_valid = 1'b0; ifa.in_data = 4'h0; ifa.in_sel = 2'd0;
    ifa.in_mode = 1'b0;  ifa.out_ready = 4'b0000;
    ifb.in_valid = 1'b0; ifb.in_data = 4'h0; ifb.in_sel = 2'd0;
    ifb.in_mode = 1'b0;  ifb.out_ready = 3'b000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic m_reset();
    for (int k = 0; k < NA; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 4'h0;
    end
    m_ptr = 0; m_beat = 0; m_err = 1'b0;
  endtask

  function automatic int m_target();
    int t;
    if (ifa.in_mode) t = m_ptr;
    else             t = int'(ifa.in_sel);
    return t;
  endfunction

  function automatic bit m_ready();
    int t;
    t = m_target();
    if (t >= NA) return 1'b1;
    return !m_full[t] || ifa.out_ready[t];
  endfunction

  // Apply one clock of the model using the currently driven inputs
  task automatic m_step();
    int t;
    bit acc;
    t   = m_target();
    acc = ifa.in_valid && m_ready();
    for (int k = 0; k < NA; k++) begin
      if (ifa.out_ready[k]) m_full[k] = 1'b0;
    end
    m_err = acc && (t >= NA);
    if (acc && t < NA) begin
      m_full[t] = 1'b1;
      m_data[t] = ifa.in_data;
      m_beat    = (m_beat + 1) % 256;
    end
    if (acc && ifa.in_mode) m_ptr = (m_ptr + 1) % NA;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    n_checks++; if (ifa.out_valid !== 4'b0000) $display("FAIL rst_valid_a got %b want 0000", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_data !== 16'h0000) $display("FAIL rst_data_a got %h want 0000", ifa.out_data); else n_pass++;
    n_checks++; if (rr_a !== 2'd0) $display("FAIL rst_ptr_a got %0d want 0", rr_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0) $display("FAIL rst_err_a got %b want 0", err_a); else n_pass++;
    n_checks++; if (beat_a !== 8'd0) $display("FAIL rst_beat_a got %0d want 0", beat_a); else n_pass++;
    n_checks++; if (ifb.out_valid !== 3'b000) $display("FAIL rst_valid_b got %b want 000", ifb.out_valid); else n_pass++;
    n_checks++; if (beat_b !== 8'd0) $display("FAIL rst_beat_b got %0d want 0", beat_b); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sel_basic();
    ifa.in_mode = 1'b0; ifa.in_sel = 2'd2; ifa.in_data = 4'hA;
    ifa.in_valid = 1'b1; ifa.out_ready = 4'b0000;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL sel_ready got %b want 1", ifa.in_ready); else n_pass++;
    tick();
    ifa.in_valid = 1'b0;
    n_checks++; if (ifa.out_valid !== 4'b0100) $display("FAIL sel_valid got %b want 0100", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_data[11:8] !== 4'hA) $display("FAIL sel_data got %h want a", ifa.out_data[11:8]); else n_pass++;
    n_checks++; if (beat_a !== 8'd1) $display("FAIL sel_beat got %0d want 1", beat_a); else n_pass++;
  endtask

  task automatic test_backpressure();
    ifa.in_mode = 1'b0; ifa.in_sel = 2'd2; ifa.in_data = 4'h3;
    ifa.in_valid = 1'b1; ifa.out_ready = 4'b0000;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL bp_stall got %b want 0", ifa.in_ready); else n_pass++;
    ifa.in_sel = 2'd0; ifa.in_data = 4'h7;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL bp_other got %b want 1", ifa.in_ready); else n_pass++;
    tick();
    ifa.in_valid = 1'b0;
    n_checks++; if (ifa.out_valid !== 4'b0101) $display("FAIL bp_valid got %b want 0101", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_data[3:0] !== 4'h7) $display("FAIL bp_ch0 got %h want 7", ifa.out_data[3:0]); else n_pass++;
    n_checks++; if (ifa.out_data[11:8] !== 4'hA) $display("FAIL bp_ch2 got %h want a", ifa.out_data[11:8]); else n_pass++;
    n_checks++; if (beat_a !== 8'd2) $display("FAIL bp_beat got %0d want 2", beat_a); else n_pass++;
  endtask

  task automatic test_rr();
    int ch;
    logic [3:0] exp_v;
    do_reset();
    ifa.in_mode = 1'b1; ifa.out_ready = 4'hF; ifa.in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      ifa.in_data = 4'(i);
      tick();
      ch = (i - 1) % NA;
      exp_v = 4'b0000;
      exp_v[ch] = 1'b1;
      n_checks++; if (ifa.out_valid !== exp_v) $display("FAIL rr_valid%0d got %b want %b", i, ifa.out_valid, exp_v); else n_pass++;
      n_checks++; if (ifa.out_data[ch*W +: W] !== 4'(i)) $display("FAIL rr_data%0d got %h want %h", i, ifa.out_data[ch*W +: W], 4'(i)); else n_pass++;
    end
    ifa.in_valid = 1'b0;
    n_checks++; if (rr_a !== 2'd2) $display("FAIL rr_ptr got %0d want 2", rr_a); else n_pass++;
    n_checks++; if (beat_a !== 8'd6) $display("FAIL rr_beat got %0d want 6", beat_a); else n_pass++;
    tick();
  endtask

  task automatic test_rr_stall();
    // Fill channel 1 by select, then channels 2,3,0 by round-robin -> ptr=1
    ifa.out_ready = 4'b0000;
    ifa.in_mode = 1'b0; ifa.in_sel = 2'd1; ifa.in_data = 4'hE; ifa.in_valid = 1'b1;
    tick();
    ifa.in_mode = 1'b1; ifa.in_data = 4'h1;
    tick(); tick(); tick();
    #1;
    n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", ifa.in_ready); else n_pass++;
    tick();
    n_checks++; if (rr_a !== 2'd1) $display("FAIL stall_ptr got %0d want 1", rr_a); else n_pass++;
    n_checks++; if (ifa.out_data[7:4] !== 4'hE) $display("FAIL stall_hold got %h want e", ifa.out_data[7:4]); else n_pass++;
    ifa.out_ready = 4'b0010; ifa.in_data = 4'h9;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL stall_release got %b want 1", ifa.in_ready); else n_pass++;
    tick();
    ifa.in_valid = 1'b0; ifa.out_ready = 4'b0000;
    n_checks++; if (ifa.out_valid !== 4'b1111) $display("FAIL stall_valid got %b want 1111", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_data[7:4] !== 4'h9) $display("FAIL stall_replace got %h want 9", ifa.out_data[7:4]); else n_pass++;
    n_checks++; if (rr_a !== 2'd2) $display("FAIL stall_ptr2 got %0d want 2", rr_a); else n_pass++;
    n_checks++; if (beat_a !== 8'd11) $display("FAIL stall_beat got %0d want 11", beat_a); else n_pass++;
  endtask

  task automatic test_bad_sel();
    ifb.in_mode = 1'b0; ifb.in_sel = 2'd0; ifb.in_data = 4'hC;
    ifb.in_valid = 1'b1; ifb.out_ready = 3'b000;
    tick();
    ifb.in_sel = 2'd3; ifb.in_data = 4'h5;
    #1;
    n_checks++; if (ifb.in_ready !== 1'b1) $display("FAIL bad_ready got %b want 1", ifb.in_ready); else n_pass++;
    n_checks++; if (err_b !== 1'b0) $display("FAIL bad_err_pre got %b want 0", err_b); else n_pass++;
    tick();
    ifb.in_valid = 1'b0;
    n_checks++; if (err_b !== 1'b1) $display("FAIL bad_err got %b want 1", err_b); else n_pass++;
    n_checks++; if (ifb.out_valid !== 3'b001) $display("FAIL bad_valid got %b want 001", ifb.out_valid); else n_pass++;
    n_checks++; if (ifb.out_data[3:0] !== 4'hC) $display("FAIL bad_data got %h want c", ifb.out_data[3:0]); else n_pass++;
    n_checks++; if (beat_b !== 8'd1) $display("FAIL bad_beat got %0d want 1", beat_b); else n_pass++;
    tick();
    n_checks++; if (err_b !== 1'b0) $display("FAIL bad_pulse got %b want 0", err_b); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] exp_v;
    do_reset();
    m_reset();
    for (int c = 0; c < 400; c++) begin
      ifa.in_valid  = ($urandom_range(0, 3) != 0);
      ifa.in_mode   = 1'($urandom_range(0, 1));
      ifa.in_sel    = 2'($urandom_range(0, 3));
      ifa.in_data   = 4'($urandom);
      ifa.out_ready = 4'($urandom);
      #1;
      n_checks++; if (ifa.in_ready !== m_ready()) $display("FAIL rnd_ready c%0d got %b want %b", c, ifa.in_ready, m_ready()); else n_pass++;
      m_step();
      tick();
      exp_v = 4'b0000;
      for (int k = 0; k < NA; k++) exp_v[k] = m_full[k];
      n_checks++; if (ifa.out_valid !== exp_v) $display("FAIL rnd_valid c%0d got %b want %b", c, ifa.out_valid, exp_v); else n_pass++;
      for (int k = 0; k < NA; k++) begin
        if (m_full[k]) begin
          n_checks++; if (ifa.out_data[k*W +: W] !== m_data[k]) $display("FAIL rnd_data c%0d ch%0d got %h want %h", c, k, ifa.out_data[k*W +: W], m_data[k]); else n_pass++;
        end
      end
      n_checks++; if (rr_a !== 2'(m_ptr)) $display("FAIL rnd_ptr c%0d got %0d want %0d", c, rr_a, m_ptr); else n_pass++;
      n_checks++; if (beat_a !== 8'(m_beat)) $display("FAIL rnd_beat c%0d got %0d want %0d", c, beat_a, m_beat); else n_pass++;
      n_checks++; if (err_a !== m_err) $display("FAIL rnd_err c%0d got %b want %b", c, err_a, m_err); else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    ifa.in_mode = 1'b0; ifa.in_sel = 2'd1; ifa.out_ready = 4'b0010;
    ifa.in_valid = 1'b1; ifa.in_data = 4'h6;
    repeat (255) tick();
    n_checks++; if (beat_a !== 8'd255) $display("FAIL wrap_255 got %0d want 255", beat_a); else n_pass++;
    tick();
    n_checks++; if (beat_a !== 8'd0) $display("FAIL wrap_0 got %0d want 0", beat_a); else n_pass++;
    n_checks++; if (ifa.out_valid !== 4'b0010) $display("FAIL wrap_valid got %b want 0010", ifa.out_valid); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    ifa.in_mode = 1'b1; ifa.out_ready = 4'b0000; ifa.in_valid = 1'b1; ifa.in_data = 4'hB;
    repeat (3) tick();
    ifa.in_valid = 1'b0;
    n_checks++; if (ifa.out_valid !== 4'b0111) $display("FAIL ar_fill got %b want 0111", ifa.out_valid); else n_pass++;
    n_checks++; if (rr_a !== 2'd3) $display("FAIL ar_ptr_pre got %0d want 3", rr_a); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ifa.out_valid !== 4'b0000) $display("FAIL ar_valid got %b want 0000", ifa.out_valid); else n_pass++;
    n_checks++; if (rr_a !== 2'd0) $display("FAIL ar_ptr got %0d want 0", rr_a); else n_pass++;
    n_checks++; if (beat_a !== 8'd0) $display("FAIL ar_beat got %0d want 0", beat_a); else n_pass++;
    n_checks++; if (ifa.out_data !== 16'h0000) $display("FAIL ar_data got %h want 0000", ifa.out_data); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sel_basic();
    test_backpressure();
    test_rr();
    test_rr_stall();
    test_bad_sel();
    test_random();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer; the distributing counterpart of the team's combinational 4-bit muxes.
- Takes one valid/ready input stream of WIDTH-bit words and steers each accepted word to one of N output channels.
- The target channel comes from a sideband select or an internal round-robin pointer.
- Each output channel owns a one-entry holding slot, so input backpressure is per-target and a stalled consumer never blocks words bound elsewhere on later cycles.

Parameters:
- WIDTH, 4, data word width.
- N, 4, number of output channels (2..16).
- SELW, $clog2(N), select/pointer width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  input word.
- in_sel  in  SELW  target channel when in_mode=0.
- in_mode  in  1  0 = sideband select (MODE_SEL), 1 = round-robin (MODE_RR).
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid&in_ready.
- out_data  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  N  channel k slot full.
- out_ready  in  N  channel k consumer takes the word when out_valid[k]&out_ready[k].
- rr_ptr  out  SELW  current round-robin pointer.
- sel_err  out  1  one-cycle pulse: a word addressed to a channel >= N was discarded.
- beat_cnt  out  8  count of words delivered into slots; wraps 255->0.

Behaviour:
- Reset (async assert, sync release): all out_valid=0, out_data=0, rr_ptr=0, sel_err=0, beat_cnt=0. Reset mid-transfer drops slot contents, with no partial delivery.
- Target t = in_mode ? rr_ptr : in_sel. Sampled combinationally each cycle.
- Slot k states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
  - EMPTY->FULL on accept with t=k.
  - FULL->EMPTY on out_ready[k] with no new accept to k.
  - FULL->FULL (data replaced) on simultaneous drain and accept to k.
- in_ready is combinational:
  - If t<N: in_ready = ~out_valid[t] | out_ready[t], so full throughput holds on one channel.
  - If t>=N (only possible when N is not a power of two, MODE_SEL): in_ready=1. The word is discarded, sel_err pulses the next cycle, no slot changes and beat_cnt holds.
- Latency: a word accepted in cycle c appears on out_data/out_valid of channel t in cycle c+1.
- out_data[k] holds its value while FULL and not drained. It keeps its last value after draining (don't-care when out_valid=0).
- in_ready has no combinational path from in_data. It depends only on in_sel, in_mode, rr_ptr, out_valid and out_ready.
- Round-robin pointer:
  - Advances only on an accepted word in MODE_RR: rr_ptr <= (rr_ptr==N-1) ? 0 : rr_ptr+1.
  - Holds in MODE_SEL and when not accepted.
  - A stalled target in MODE_RR stalls the input; the pointer does not skip the channel.
- Mode may change on any cycle and takes effect on the same cycle's target.
- beat_cnt increments by 1 per word accepted into a slot; it is not incremented by discarded words.
- Slot draining is independent per channel; any subset of channels may drain in one cycle.

Decomposition:
- Package demux_pkg:
  - typedef enum logic {MODE_SEL, MODE_RR} demux_mode_t.
  - localparam DEMUX_WIDTH_DEF=4.
  - localparam BEAT_CNT_W=8.
- Sub-module demux_slot: one-entry WIDTH-bit register with load/valid/ready, instantiated N times in a generate loop.
- Pointer, error pulse and counter stay in the top module.

Test Plan:
- Reset then MODE_SEL, in_sel=2, in_data=4'hA, in_valid=1, all out_ready=0 -> next cycle out_valid=4'b0100, channel 2 data=4'hA, beat_cnt=1.
- Channel 2 stays full, out_ready[2]=0, second word in_sel=2 -> in_ready=0. Same cycle with in_sel=0 -> in_ready=1, and channel 0 loads next cycle.
- MODE_RR, out_ready=4'hF, in_valid held 6 cycles with data 1..6:
  - Channels receive 1,2,3,4,5,6 in order 0,1,2,3,0,1.
  - rr_ptr ends at 2; beat_cnt=6.
- MODE_RR, out_ready[1]=0 with channel 1 full and rr_ptr=1 -> in_ready=0 and rr_ptr stays 1. Raising out_ready[1] -> accept, slot replaced in the same cycle, rr_ptr=2.
- N=3, MODE_SEL, in_sel=3, in_data=4'h5 -> in_ready=1, sel_err=1 next cycle, out_valid unchanged, beat_cnt unchanged.
- 256 accepted words -> beat_cnt wraps to 0. Assert rst_n=0 with slots full -> out_valid=0 immediately (asynchronous), rr_ptr=0.
